// File: rtl/lifo_fifo_buffer.sv
// Run-time selectable LIFO stack / FIFO queue over one storage array.
// Show-ahead read data, occupancy count, programmable almost flags,
// one-cycle overflow/underflow pulses and a synchronous flush.
module lifo_fifo_buffer #(
  parameter int unsigned DATA_SIZE        = 8,
  parameter int unsigned ADDR_SPACE_EXP   = 4,
  parameter int unsigned ALMOST_FULL_LVL  = 2**ADDR_SPACE_EXP - 2,
  parameter int unsigned ALMOST_EMPTY_LVL = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mode,
  input  logic                      clear,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_SIZE-1:0]      push_data_in,
  output logic [DATA_SIZE-1:0]      pop_data_out,
  output logic                      mode_active,
  output logic [ADDR_SPACE_EXP:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned AW    = ADDR_SPACE_EXP;
  localparam int unsigned CW    = ADDR_SPACE_EXP + 1;
  localparam int unsigned Depth = 2**ADDR_SPACE_EXP;

  localparam logic [CW-1:0] DepthCnt = CW'(Depth);
  localparam logic [CW-1:0] AfLvl    = CW'(ALMOST_FULL_LVL);
  localparam logic [CW-1:0] AeLvl    = CW'(ALMOST_EMPTY_LVL);
  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [AW-1:0] PtrOne   = AW'(1);

  logic [DATA_SIZE-1:0] mem [Depth];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          mode_q, mode_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          mem_we;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] top_addr;
  logic [AW-1:0] rd_addr;
  logic          push_acc;
  logic          pop_acc;

  assign top_addr = wr_ptr_q - PtrOne;

  // Flags and show-ahead data decode from registered state only.
  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == DepthCnt);
    almost_full  = (count_q >= AfLvl);
    almost_empty = (count_q <= AeLvl);
    count        = count_q;
    mode_active  = mode_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
    rd_addr      = mode_q ? top_addr : rd_ptr_q;
    pop_data_out = empty ? '0 : mem[rd_addr];
  end

  // Next-state: mode latch, clear, and per-mode push/pop resolution.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mode_d      = mode_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    wr_addr     = wr_ptr_q;
    push_acc    = 1'b0;
    pop_acc     = 1'b0;

    if (empty || clear) begin
      mode_d = mode;
    end

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!mode_q) begin
      // FIFO. While empty, re-align rd_ptr to wr_ptr so a queue entered
      // from LIFO mode starts reading where it will start writing.
      push_acc = push && !full;
      pop_acc  = pop && !empty;
      if (empty) begin
        rd_ptr_d = wr_ptr_q;
      end
      if (push_acc) begin
        mem_we   = 1'b1;
        wr_addr  = wr_ptr_q;
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      overflow_d  = push && !push_acc;
      underflow_d = pop && !pop_acc;
      if (push_acc && !pop_acc) begin
        count_d = count_q + CntOne;
      end else if (pop_acc && !push_acc) begin
        count_d = count_q - CntOne;
      end
    end else begin
      // LIFO. An empty stack rebases to address 0 so that switching back
      // to FIFO (rd_ptr = 0) sees consistent pointers.
      rd_ptr_d = '0;
      if (push && pop && !empty) begin
        mem_we  = 1'b1;
        wr_addr = top_addr;
      end else if (push) begin
        if (full) begin
          overflow_d = 1'b1;
        end else begin
          mem_we   = 1'b1;
          wr_addr  = empty ? '0 : wr_ptr_q;
          wr_ptr_d = (empty ? '0 : wr_ptr_q) + PtrOne;
          count_d  = count_q + CntOne;
        end
        underflow_d = pop;
      end else if (pop) begin
        if (empty) begin
          underflow_d = 1'b1;
        end else begin
          wr_ptr_d = top_addr;
          count_d  = count_q - CntOne;
        end
      end else if (empty) begin
        wr_ptr_d = '0;
      end
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mode_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_addr] <= push_data_in;
    end
  end

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Bench for lifo_fifo_buffer: directed test-plan steps followed by random
// traffic, all checked against a queue-based reference model.
module tb_lifo_fifo_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned AE = 2;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset_n;
  logic          mode;
  logic          clear;
  logic          push;
  logic          pop;
  logic [DW-1:0] push_data_in;
  logic [DW-1:0] pop_data_out;
  logic          mode_active;
  logic [AE:0]   count;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic          m_mode;
  logic          m_ovf;
  logic          m_unf;

  lifo_fifo_buffer #(
    .DATA_SIZE       (8),
    .ADDR_SPACE_EXP  (2),
    .ALMOST_FULL_LVL (3),
    .ALMOST_EMPTY_LVL(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mode        (mode),
    .clear       (clear),
    .push        (push),
    .pop         (pop),
    .push_data_in(push_data_in),
    .pop_data_out(pop_data_out),
    .mode_active (mode_active),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_head();
    if (mq.size() == 0) return '0;
    if (m_mode) return mq[mq.size()-1];
    return mq[0];
  endfunction

  task automatic model_reset();
    mq.delete();
    m_mode = 1'b0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock edge of behaviour, using the state held before the edge.
  task automatic model_step(input logic p, input logic o, input logic [DW-1:0] d,
                            input logic m, input logic c);
    int  n;
    logic next_mode;
    n         = mq.size();
    next_mode = (c || n == 0) ? m : m_mode;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    if (c) begin
      mq.delete();
    end else if (!m_mode) begin
      if (o) begin
        if (n > 0) void'(mq.pop_front());
        else m_unf = 1'b1;
      end
      if (p) begin
        if (n < DEPTH) mq.push_back(d);
        else m_ovf = 1'b1;
      end
    end else begin
      if (p && o && n > 0) begin
        mq[n-1] = d;
      end else begin
        if (p) begin
          if (n < DEPTH) mq.push_back(d);
          else m_ovf = 1'b1;
        end
        if (o) begin
          if (n > 0) void'(mq.pop_back());
          else m_unf = 1'b1;
        end
      end
    end
    m_mode = next_mode;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".empty"}, 32'(empty), 32'(n == 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".afull"}, 32'(almost_full), 32'(n >= 3));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= 1));
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(m_unf));
    check({tag, ".mode"}, 32'(mode_active), 32'(m_mode));
    check({tag, ".data"}, 32'(pop_data_out), 32'(model_head()));
  endtask

  task automatic step(input string tag, input logic p, input logic o,
                      input logic [DW-1:0] d, input logic m, input logic c);
    push         = p;
    pop          = o;
    push_data_in = d;
    mode         = m;
    clear        = c;
    @(posedge clk);
    model_step(p, o, d, m, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [DW-1:0] fifo_exp [4];
    logic [DW-1:0] lifo_exp [3];
    fifo_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    lifo_exp = '{8'hB0, 8'hA2, 8'hA1};

    reset_n = 1'b0;
    push = 1'b0; pop = 1'b0; mode = 1'b0; clear = 1'b0; push_data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;
    step("idle", 0, 0, 8'h00, 0, 0);

    // FIFO fill, overflow, drain, underflow.
    step("f_push1", 1, 0, 8'h11, 0, 0);
    step("f_push2", 1, 0, 8'h22, 0, 0);
    step("f_push3", 1, 0, 8'h33, 0, 0);
    step("f_push4", 1, 0, 8'h44, 0, 0);
    check("f_full_const", 32'(full), 32'd1);
    check("f_count_const", 32'(count), 32'd4);
    step("f_ovf", 1, 0, 8'h55, 0, 0);
    check("f_ovf_const", 32'(overflow), 32'd1);
    step("f_ovf_clr", 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("f_order", 32'(pop_data_out), 32'(fifo_exp[i]));
      step("f_pop", 0, 1, 8'h00, 0, 0);
    end
    step("f_unf", 0, 1, 8'h00, 0, 0);
    check("f_unf_const", 32'(underflow), 32'd1);

    // LIFO with replace-top.
    step("l_latch", 0, 0, 8'h00, 1, 0);
    step("l_push1", 1, 0, 8'hA1, 1, 0);
    step("l_push2", 1, 0, 8'hA2, 1, 0);
    step("l_push3", 1, 0, 8'hA3, 1, 0);
    check("l_top_const", 32'(pop_data_out), 32'hA3);
    step("l_replace", 1, 1, 8'hB0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      check("l_order", 32'(pop_data_out), 32'(lifo_exp[i]));
      step("l_pop", 0, 1, 8'h00, 1, 0);
    end
    step("l_pp_empty", 1, 1, 8'hC5, 1, 0);
    step("l_pop_last", 0, 1, 8'h00, 1, 0);

    // FIFO pointer wrap and push+pop while full.
    step("w_latch", 0, 0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) step("w_push", 1, 0, 8'(8'h60 + i), 0, 0);
    for (int i = 0; i < 3; i++) step("w_pop", 0, 1, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) step("w_push4", 1, 0, 8'(8'h70 + i), 0, 0);
    step("w_pp_full", 1, 1, 8'h7F, 0, 0);
    check("w_pp_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step("w_drain", 0, 1, 8'h00, 0, 0);

    // Mode ignored while occupied; clear latches mode.
    step("m_push1", 1, 0, 8'h81, 0, 0);
    step("m_push2", 1, 0, 8'h82, 0, 0);
    step("m_ignored", 0, 0, 8'h00, 1, 0);
    step("m_clear", 1, 1, 8'h99, 1, 1);
    check("m_clear_mode", 32'(mode_active), 32'd1);

    // Asynchronous reset mid-burst.
    step("r_push1", 1, 0, 8'hD1, 1, 0);
    step("r_push2", 1, 0, 8'hD2, 1, 0);
    step("r_push3", 1, 0, 8'hD3, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      logic p, o, m, c;
      p = ($urandom_range(0, 99) < 55);
      o = ($urandom_range(0, 99) < 45);
      m = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 31) == 0);
      step("rand", p, o, 8'($urandom), m, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
